// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for a shared-memory RV32I datapath; defining CONTROL_UNIT_INSTRET_EN adds the instret retirement counter
module multicycle_control_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  LT,
  input  logic                  mem_ready,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic [1:0]            PCsrc,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic                  MEMRead,
  output logic                  MEMWrite,
  output logic                  fault,
  output logic [2:0]            state
`ifdef CONTROL_UNIT_INSTRET_EN
  ,
  output logic [31:0]           instret
`endif
);
  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b111
  } state_t;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic [6:0] op;
  logic [2:0] f3;
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr;
  logic legal, taken, timeout;
  logic unused_instr;
  assign op           = instr[6:0];
  assign f3           = instr[14:12];
  assign unused_instr = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};
  assign is_r    = op == OP_R;
  assign is_i    = op == OP_I;
  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_br   = op == OP_BR;
  assign is_jal  = op == OP_JAL;
  assign is_jalr = op == OP_JALR;
  assign legal = is_r || is_i || is_jal
              || ((is_lw || is_sw) && f3 == 3'b010)
              || (is_br && f3[1] == 1'b0)
              || (is_jalr && f3 == 3'b000);
  // funct3[2] picks LT vs EQ, funct3[0] inverts (BNE/BGE)
  assign taken   = (f3[2] ? LT : EQ) ^ f3[0];
  assign timeout = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT));
  assign state   = cur;
  function automatic logic [2:0] alu_map(input logic [2:0] f);
    return f == 3'b000 ? 3'b000 :
           f == 3'b111 ? 3'b010 :
           f == 3'b110 ? 3'b011 :
           f == 3'b100 ? 3'b100 :
           f == 3'b010 ? 3'b101 :
           f == 3'b001 ? 3'b110 :
           f == 3'b101 ? 3'b111 : 3'b000;
  endfunction
  always_comb begin
    nxt       = cur;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 2'b00;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUctrl   = 3'b000;
    ALUsrc    = 1'b0;
    ImmSrc    = 2'b00;
    MEMRead   = 1'b0;
    MEMWrite  = 1'b0;
    fault     = 1'b0;
    case (cur)
      FETCH: begin
        MEMRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt     = mem_ready ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: nxt = legal ? EXEC : TRAP;
      EXEC: begin
        if (is_r || is_i) begin
          ALUsrc  = is_i;
          ALUctrl = (is_r && f3 == 3'b000 && instr[30]) ? 3'b001 : alu_map(f3);
          nxt     = WB;
        end else if (is_lw || is_sw) begin
          ALUsrc = 1'b1;
          ImmSrc = is_sw ? 2'b01 : 2'b00;
          nxt    = MEM;
        end else if (is_br) begin
          ALUctrl = 3'b001;
          ImmSrc  = 2'b10;
          PCsrc   = 2'b01;
          PCWrite = taken;
          nxt     = FETCH;
        end else if (is_jal || is_jalr) begin
          ImmSrc    = is_jal ? 2'b11 : 2'b00;
          PCsrc     = is_jal ? 2'b01 : 2'b10;
          PCWrite   = 1'b1;
          RegWrite  = 1'b1;
          ResultSrc = 2'b10;
          nxt       = FETCH;
        end else begin
          nxt = TRAP;
        end
      end
      MEM: begin
        MEMRead  = is_lw;
        MEMWrite = is_sw;
        nxt      = mem_ready ? (is_lw ? WB : FETCH) : timeout ? TRAP : MEM;
      end
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_lw ? 2'b01 : 2'b00;
        nxt       = FETCH;
      end
      TRAP: fault = 1'b1;
      default: nxt = TRAP;
    endcase
    if (rst) begin
      nxt       = FETCH;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 2'b00;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUctrl   = 3'b000;
      ALUsrc    = 1'b0;
      ImmSrc    = 2'b00;
      MEMRead   = 1'b0;
      MEMWrite  = 1'b0;
      fault     = 1'b0;
    end
  end
  // counter runs only while waiting in FETCH/MEM, so it is zero on every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= ((cur == FETCH || cur == MEM) && nxt == cur) ? cnt + CW'(1) : '0;
    end
  end
`ifdef CONTROL_UNIT_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst)
      instret <= '0;
    else if (nxt == FETCH && (cur == EXEC || cur == MEM || cur == WB))
      instret <= instret + 32'd1;
  end
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed-vector bench for the multicycle control unit
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst, EQ, LT, mem_ready;
  logic [31:0] instr;
  logic IRWrite, PCWrite, RegWrite, ALUsrc, MEMRead, MEMWrite, fault;
  logic [1:0] PCsrc, ResultSrc, ImmSrc;
  logic [2:0] ALUctrl, state;
`ifdef CONTROL_UNIT_INSTRET_EN
  logic [31:0] instret;
`endif
  int checks = 0;
  int errors = 0;
  logic [18:0] obs, e, f_rdy, f_wait, idle, dec, wb_alu, wb_lw, trap_v;
  multicycle_control_unit #(.DATA_WIDTH(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .LT(LT), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .MEMRead(MEMRead), .MEMWrite(MEMWrite), .fault(fault), .state(state)
`ifdef CONTROL_UNIT_INSTRET_EN
    , .instret(instret)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {state, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc, ALUctrl, ALUsrc, ImmSrc, MEMRead, MEMWrite, fault};
  function automatic logic [18:0] ctl(input logic [2:0] st, input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] rs, input logic [2:0] alu, input logic asrc,
                                      input logic [1:0] imm, input logic mr, input logic mw, input logic f);
    return {st, irw, pcw, pcs, rw, rs, alu, asrc, imm, mr, mw, f};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [31:0] i);
    instr = i;
    mem_ready = 1'b1;
    tick();
    tick();
  endtask
  task automatic do_reset;
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; EQ = 1'b0; LT = 1'b0;
    tick();
    tick();
    checks++; if (obs !== idle) begin errors++; $display("FAIL reset_hold: got %b exp %b", obs, idle); end
    rst = 1'b0;
    #1;
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL reset_release: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_addi;
    instr = 32'h00500093; mem_ready = 1'b1;
    #1;
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL addi_fetch: got %b exp %b", obs, f_rdy); end
    tick();
    checks++; if (obs !== dec) begin errors++; $display("FAIL addi_decode: got %b exp %b", obs, dec); end
    tick();
    e = ctl(3'b010, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b00, 0, 0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL addi_exec: got %b exp %b", obs, e); end
    tick();
    checks++; if (obs !== wb_alu) begin errors++; $display("FAIL addi_wb: got %b exp %b", obs, wb_alu); end
    tick();
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL addi_next_fetch: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_alu_ops;
    logic [31:0] ins [4];
    logic [3:0] ex [4];
    ins = '{32'h402081B3, 32'h0020C1B3, 32'h0020D093, 32'h40000093};
    ex  = '{{3'b001, 1'b0}, {3'b100, 1'b0}, {3'b111, 1'b1}, {3'b000, 1'b1}};
    for (int k = 0; k < 4; k++) begin
      fetch_decode(ins[k]);
      e = ctl(3'b010, 0, 0, 2'b00, 0, 2'b00, ex[k][3:1], ex[k][0], 2'b00, 0, 0, 0);
      checks++; if (obs !== e) begin errors++; $display("FAIL alu_exec[%0d]: got %b exp %b", k, obs, e); end
      tick();
      checks++; if (obs !== wb_alu) begin errors++; $display("FAIL alu_wb[%0d]: got %b exp %b", k, obs, wb_alu); end
      tick();
    end
  endtask
  task automatic test_lw;
    fetch_decode(32'h0000A283);
    e = ctl(3'b010, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b00, 0, 0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL lw_exec: got %b exp %b", obs, e); end
    mem_ready = 1'b0;
    e = ctl(3'b011, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) begin mem_ready = 1'b1; #1; end
      checks++; if (obs !== e) begin errors++; $display("FAIL lw_mem[%0d]: got %b exp %b", k, obs, e); end
    end
    tick();
    checks++; if (obs !== wb_lw) begin errors++; $display("FAIL lw_wb: got %b exp %b", obs, wb_lw); end
    tick();
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL lw_next_fetch: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_sw;
    fetch_decode(32'h0020A223);
    e = ctl(3'b010, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 2'b01, 0, 0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL sw_exec: got %b exp %b", obs, e); end
    tick();
    e = ctl(3'b011, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL sw_mem: got %b exp %b", obs, e); end
    tick();
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL sw_next_fetch: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_branch;
    logic [31:0] ins [8];
    logic [2:0] v [8];
    ins = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463,
            32'h0020C463, 32'h0020C463, 32'h0020D463, 32'h0020D463};
    v   = '{3'b101, 3'b010, 3'b011, 3'b100, 3'b011, 3'b100, 3'b101, 3'b010};
    for (int k = 0; k < 8; k++) begin
      fetch_decode(ins[k]);
      EQ = v[k][2]; LT = v[k][1];
      #1;
      e = ctl(3'b010, 0, v[k][0], 2'b01, 0, 2'b00, 3'b001, 0, 2'b10, 0, 0, 0);
      checks++; if (obs !== e) begin errors++; $display("FAIL branch_exec[%0d]: got %b exp %b", k, obs, e); end
      tick();
      checks++; if (obs !== f_rdy) begin errors++; $display("FAIL branch_next[%0d]: got %b exp %b", k, obs, f_rdy); end
    end
    EQ = 1'b0; LT = 1'b0;
  endtask
  task automatic test_jumps;
    fetch_decode(32'h008000EF);
    e = ctl(3'b010, 0, 1, 2'b01, 1, 2'b10, 3'b000, 0, 2'b11, 0, 0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL jal_exec: got %b exp %b", obs, e); end
    tick();
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL jal_next: got %b exp %b", obs, f_rdy); end
    fetch_decode(32'h000080E7);
    e = ctl(3'b010, 0, 1, 2'b10, 1, 2'b10, 3'b000, 0, 2'b00, 0, 0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL jalr_exec: got %b exp %b", obs, e); end
    tick();
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL jalr_next: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_late_ready;
    instr = 32'h00500093; mem_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      checks++; if (obs !== f_wait) begin errors++; $display("FAIL late_wait[%0d]: got %b exp %b", k, obs, f_wait); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL late_ready_wins: got %b exp %b", obs, f_rdy); end
    tick();
    checks++; if (obs !== dec) begin errors++; $display("FAIL late_decode: got %b exp %b", obs, dec); end
    tick();
    tick();
    tick();
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL late_next_fetch: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_fetch_timeout;
    mem_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if (obs !== f_wait) begin errors++; $display("FAIL to_wait[%0d]: got %b exp %b", k, obs, f_wait); end
      tick();
    end
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL fetch_timeout_trap: got %b exp %b", obs, trap_v); end
    mem_ready = 1'b1;
    tick();
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL trap_sticky: got %b exp %b", obs, trap_v); end
    rst = 1'b1;
    #1;
    e = ctl(3'b111, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0);
    checks++; if (obs !== e) begin errors++; $display("FAIL reset_in_trap: got %b exp %b", obs, e); end
    tick();
    checks++; if (obs !== idle) begin errors++; $display("FAIL reset_to_fetch: got %b exp %b", obs, idle); end
    rst = 1'b0;
    #1;
    checks++; if (obs !== f_rdy) begin errors++; $display("FAIL trap_recover: got %b exp %b", obs, f_rdy); end
  endtask
  task automatic test_illegal;
    instr = 32'h0000007F; mem_ready = 1'b1;
    tick();
    checks++; if (obs !== dec) begin errors++; $display("FAIL bad_op_decode: got %b exp %b", obs, dec); end
    tick();
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL bad_op_trap: got %b exp %b", obs, trap_v); end
    do_reset();
    fetch_decode(32'h0000B283);
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL bad_lw_f3: got %b exp %b", obs, trap_v); end
    do_reset();
    fetch_decode(32'h0000A0E7 & 32'hFFFF9FFF | 32'h00001000);
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL bad_jalr_f3: got %b exp %b", obs, trap_v); end
    do_reset();
    fetch_decode(32'h0020A463);
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL bad_br_f3: got %b exp %b", obs, trap_v); end
    do_reset();
  endtask
  task automatic test_mem_timeout;
    fetch_decode(32'h0000A283);
    mem_ready = 1'b0;
    tick();
    e = ctl(3'b011, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs !== e) begin errors++; $display("FAIL mem_wait[%0d]: got %b exp %b", k, obs, e); end
      tick();
    end
    checks++; if (obs !== trap_v) begin errors++; $display("FAIL mem_timeout_trap: got %b exp %b", obs, trap_v); end
    do_reset();
  endtask
`ifdef CONTROL_UNIT_INSTRET_EN
  task automatic test_instret;
    do_reset();
    #1;
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL instret_reset: got %0d exp 0", instret); end
    fetch_decode(32'h00500093);
    tick();
    tick();
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL instret_one: got %0d exp 1", instret); end
    fetch_decode(32'h0020A223);
    tick();
    tick();
    fetch_decode(32'h008000EF);
    tick();
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL instret_three: got %0d exp 3", instret); end
  endtask
`endif
  initial begin
    f_rdy  = ctl(3'b000, 1, 1, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 0);
    f_wait = ctl(3'b000, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 0);
    idle   = ctl(3'b000, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0);
    dec    = ctl(3'b001, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0);
    wb_alu = ctl(3'b100, 0, 0, 2'b00, 1, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0);
    wb_lw  = ctl(3'b100, 0, 0, 2'b00, 1, 2'b01, 3'b000, 0, 2'b00, 0, 0, 0);
    trap_v = ctl(3'b111, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 1);
    test_reset();
    test_addi();
    test_alu_ops();
    test_lw();
    test_sw();
    test_branch();
    test_jumps();
    test_late_ready();
    test_fetch_timeout();
    test_illegal();
    test_mem_timeout();
`ifdef CONTROL_UNIT_INSTRET_EN
    test_instret();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
